// File: rtl/rs_alloc_ctrl_pkg.sv
// Shared constants for the reservation-station allocator.
//   RS_ALLOC_MODE_FIXED : search for free entries from index 0 upward
//   RS_ALLOC_MODE_ROT   : search starts at a rotating pointer
// When the allocator is instantiated with ALLOC_NUM equal to the dispatch
// width, the dispatch count bus must be at least REQ_W bits wide.
package rs_alloc_ctrl_pkg;

   localparam int RS_ALLOC_MODE_FIXED = 0;
   localparam int RS_ALLOC_MODE_ROT   = 1;

   function automatic int rs_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rs_alloc_ctrl_rot_prio_sel.sv
// Combinational rotated multi-grant priority selector.
// Ports:
//   i_busy    : RS busy vector (1 = occupied)
//   i_start   : first index of the search; the search wraps modulo RS_ENT_NUM
//   o_sel     : slot k entry index at [k*RS_ENT_SEL +: RS_ENT_SEL], 0 when invalid
//   o_sel_vld : slot k valid, i.e. at least k+1 entries are free
module rs_rot_prio_sel
   import rs_alloc_ctrl_pkg::*;
#(
   parameter int RS_ENT_NUM = 8,
   parameter int RS_ENT_SEL = 3,
   parameter int ALLOC_NUM  = 2,
   parameter int CNT_W      = $clog2(RS_ENT_NUM + 1)
) (
   input  logic [RS_ENT_NUM-1:0]           i_busy,
   input  logic [RS_ENT_SEL-1:0]           i_start,
   output logic [ALLOC_NUM*RS_ENT_SEL-1:0] o_sel,
   output logic [ALLOC_NUM-1:0]            o_sel_vld
);

   localparam int IW = RS_ENT_SEL + 1;

   // Position j of the search maps to entry w_idx[j]; w_pre[j] is the number
   // of free entries seen before position j.
   logic [RS_ENT_NUM-1:0] w_rot_free;
   logic [RS_ENT_SEL-1:0] w_idx [RS_ENT_NUM];
   logic [CNT_W-1:0]      w_pre [RS_ENT_NUM];

   always_comb begin
      logic [IW-1:0]    v_sum;
      logic [CNT_W-1:0] v_acc;
      v_sum = '0;
      v_acc = '0;
      for (int j = 0; j < RS_ENT_NUM; j++) begin
         v_sum = {1'b0, i_start} + IW'(j);
         if (v_sum >= IW'(RS_ENT_NUM)) begin
            v_sum = v_sum - IW'(RS_ENT_NUM);
         end
         w_idx[j]      = v_sum[RS_ENT_SEL-1:0];
         w_rot_free[j] = ~i_busy[v_sum[RS_ENT_SEL-1:0]];
         w_pre[j]      = v_acc;
         v_acc         = v_acc + CNT_W'(w_rot_free[j]);
      end
   end

   // Slot k takes the free position that has exactly k free positions ahead of it.
   for (genvar k = 0; k < ALLOC_NUM; k++) begin : g_slot
      logic [RS_ENT_SEL-1:0] w_slot_sel;
      logic                  w_slot_vld;

      always_comb begin
         w_slot_sel = '0;
         w_slot_vld = 1'b0;
         for (int j = 0; j < RS_ENT_NUM; j++) begin
            if (w_rot_free[j] && (w_pre[j] == CNT_W'(k))) begin
               w_slot_sel = w_idx[j];
               w_slot_vld = 1'b1;
            end
         end
      end

      assign o_sel[k*RS_ENT_SEL +: RS_ENT_SEL] = w_slot_sel;
      assign o_sel_vld[k]                      = w_slot_vld;
   end

endmodule

// File: rtl/rs_alloc_ctrl.sv
// Reservation-station entry allocator. Owns the busy vector, grants up to
// ALLOC_NUM free entries per cycle, frees up to ISSUE_NUM per cycle on issue
// and clears everything on flush.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_req_num     : entries requested this cycle (0..ALLOC_NUM)
//   i_issue_vld   : per-port free strobe
//   i_issue_idx   : per-port entry to free, port k at [k*RS_ENT_SEL +: RS_ENT_SEL]
//   i_flush       : clear all entries
//   o_allocable   : i_req_num <= o_free_cnt
//   o_sel_vld     : slot k holds a valid free entry
//   o_sel         : slot k entry index
//   o_busy_vec    : registered busy bits
//   o_free_cnt    : registered free-entry count
//   o_full        : no free entries
//   o_empty       : all entries free
//   o_err         : sticky protocol error (bad or duplicate free)
module rs_alloc_ctrl
   import rs_alloc_ctrl_pkg::*;
#(
   parameter int RS_ENT_NUM = 8,
   parameter int RS_ENT_SEL = 3,
   parameter int ALLOC_NUM  = 2,
   parameter int ISSUE_NUM  = 2,
   parameter int ALLOC_MODE = RS_ALLOC_MODE_FIXED,
   parameter int REQ_W      = $clog2(ALLOC_NUM + 1),
   parameter int CNT_W      = $clog2(RS_ENT_NUM + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REQ_W-1:0]                i_req_num,
   input  logic [ISSUE_NUM-1:0]            i_issue_vld,
   input  logic [ISSUE_NUM*RS_ENT_SEL-1:0] i_issue_idx,
   input  logic                            i_flush,
   output logic                            o_allocable,
   output logic [ALLOC_NUM-1:0]            o_sel_vld,
   output logic [ALLOC_NUM*RS_ENT_SEL-1:0] o_sel,
   output logic [RS_ENT_NUM-1:0]           o_busy_vec,
   output logic [CNT_W-1:0]                o_free_cnt,
   output logic                            o_full,
   output logic                            o_empty,
   output logic                            o_err
);

   localparam int MW = rs_max(REQ_W, CNT_W);

   logic [RS_ENT_NUM-1:0] r_busy;
   logic [CNT_W-1:0]      r_free_cnt;
   logic [RS_ENT_SEL-1:0] r_ptr;
   logic                  r_err;

   logic [RS_ENT_SEL-1:0]           w_start;
   logic [ALLOC_NUM*RS_ENT_SEL-1:0] w_sel;
   logic [ALLOC_NUM-1:0]            w_sel_vld;
   logic                            w_allocable;
   logic                            w_alloc_fire;
   logic [RS_ENT_NUM-1:0]           w_alloc_mask;
   logic [RS_ENT_SEL-1:0]           w_last_idx;
   logic [RS_ENT_SEL-1:0]           w_ptr_next;
   logic [RS_ENT_NUM-1:0]           w_free_mask;
   logic                            w_issue_err;
   logic [RS_ENT_NUM-1:0]           w_busy_next;
   logic [CNT_W-1:0]                w_alloc_cnt;
   logic [CNT_W-1:0]                w_freed_cnt;
   logic [CNT_W-1:0]                w_free_cnt_next;

   // Fixed mode always searches from entry 0.
   assign w_start = (ALLOC_MODE == RS_ALLOC_MODE_ROT) ? r_ptr : '0;

   rs_rot_prio_sel #(
      .RS_ENT_NUM (RS_ENT_NUM),
      .RS_ENT_SEL (RS_ENT_SEL),
      .ALLOC_NUM  (ALLOC_NUM),
      .CNT_W      (CNT_W)
   ) u_sel (
      .i_busy    (r_busy),
      .i_start   (w_start),
      .o_sel     (w_sel),
      .o_sel_vld (w_sel_vld)
   );

   assign w_allocable  = MW'(i_req_num) <= MW'(r_free_cnt);
   assign w_alloc_fire = (i_req_num != '0) && w_allocable && !i_flush;

   // All-or-nothing grant of slots 0..i_req_num-1; o_allocable guarantees
   // those slots are valid.
   always_comb begin
      w_alloc_mask = '0;
      w_last_idx   = r_ptr;
      for (int k = 0; k < ALLOC_NUM; k++) begin
         if (w_alloc_fire && (REQ_W'(k) < i_req_num)) begin
            w_alloc_mask[w_sel[k*RS_ENT_SEL +: RS_ENT_SEL]] = 1'b1;
            w_last_idx = w_sel[k*RS_ENT_SEL +: RS_ENT_SEL];
         end
      end
   end

   assign w_ptr_next = (w_last_idx == RS_ENT_SEL'(RS_ENT_NUM - 1)) ? '0 : w_last_idx + 1'b1;

   // An index outside the entry range hits nothing and counts as a bad free.
   always_comb begin
      logic [RS_ENT_SEL-1:0] v_idx;
      logic                  v_hit;
      w_free_mask = '0;
      w_issue_err = 1'b0;
      v_idx       = '0;
      v_hit       = 1'b0;
      for (int p = 0; p < ISSUE_NUM; p++) begin
         if (i_issue_vld[p]) begin
            v_idx = i_issue_idx[p*RS_ENT_SEL +: RS_ENT_SEL];
            v_hit = 1'b0;
            for (int j = 0; j < RS_ENT_NUM; j++) begin
               if (v_idx == RS_ENT_SEL'(j)) begin
                  v_hit          = 1'b1;
                  w_free_mask[j] = 1'b1;
                  if (!r_busy[j]) begin
                     w_issue_err = 1'b1;
                  end
               end
            end
            if (!v_hit) begin
               w_issue_err = 1'b1;
            end
            for (int q = 0; q < p; q++) begin
               if (i_issue_vld[q] && (i_issue_idx[q*RS_ENT_SEL +: RS_ENT_SEL] == v_idx)) begin
                  w_issue_err = 1'b1;
               end
            end
         end
      end
   end

   // Free wins over a coinciding allocation, so only allocations that survive
   // the free are charged against the count; this keeps the count equal to
   // the popcount of ~busy_next in every case.
   assign w_busy_next = (r_busy | w_alloc_mask) & ~w_free_mask;

   always_comb begin
      w_alloc_cnt = '0;
      w_freed_cnt = '0;
      for (int j = 0; j < RS_ENT_NUM; j++) begin
         w_alloc_cnt = w_alloc_cnt + CNT_W'(w_alloc_mask[j] & ~w_free_mask[j]);
         w_freed_cnt = w_freed_cnt + CNT_W'(w_free_mask[j] & r_busy[j]);
      end
   end

   assign w_free_cnt_next = r_free_cnt - w_alloc_cnt + w_freed_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= '0;
         r_free_cnt <= CNT_W'(RS_ENT_NUM);
         r_ptr      <= '0;
         r_err      <= 1'b0;
      end else if (i_flush) begin
         r_busy     <= '0;
         r_free_cnt <= CNT_W'(RS_ENT_NUM);
         r_ptr      <= '0;
      end else begin
         r_busy     <= w_busy_next;
         r_free_cnt <= w_free_cnt_next;
         if ((ALLOC_MODE == RS_ALLOC_MODE_ROT) && w_alloc_fire) begin
            r_ptr <= w_ptr_next;
         end
         if (w_issue_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_allocable = w_allocable;
   assign o_sel_vld   = w_sel_vld;
   assign o_sel       = w_sel;
   assign o_busy_vec  = r_busy;
   assign o_free_cnt  = r_free_cnt;
   assign o_full      = (r_free_cnt == '0);
   assign o_empty     = (r_free_cnt == CNT_W'(RS_ENT_NUM));
   assign o_err       = r_err;

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Directed bench: u_dut0 runs fixed lowest-index selection, u_dut1 rotating.
module tb_rs_alloc_ctrl;

   logic       clk = 1'b0;
   logic       rst;

   logic [1:0] req0, ivld0, req1, ivld1;
   logic [5:0] iidx0, iidx1;
   logic       flush0, flush1;

   logic       alloc0, full0, empty0, err0;
   logic       alloc1, full1, empty1, err1;
   logic [1:0] selvld0, selvld1;
   logic [5:0] sel0, sel1;
   logic [7:0] busy0, busy1;
   logic [3:0] cnt0, cnt1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   rs_alloc_ctrl #(.RS_ENT_NUM(8), .RS_ENT_SEL(3), .ALLOC_NUM(2), .ISSUE_NUM(2), .ALLOC_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .i_req_num(req0), .i_issue_vld(ivld0), .i_issue_idx(iidx0),
      .i_flush(flush0), .o_allocable(alloc0), .o_sel_vld(selvld0), .o_sel(sel0),
      .o_busy_vec(busy0), .o_free_cnt(cnt0), .o_full(full0), .o_empty(empty0), .o_err(err0));

   rs_alloc_ctrl #(.RS_ENT_NUM(8), .RS_ENT_SEL(3), .ALLOC_NUM(2), .ISSUE_NUM(2), .ALLOC_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_req_num(req1), .i_issue_vld(ivld1), .i_issue_idx(iidx1),
      .i_flush(flush1), .o_allocable(alloc1), .o_sel_vld(selvld1), .o_sel(sel1),
      .o_busy_vec(busy1), .o_free_cnt(cnt1), .o_full(full1), .o_empty(empty1), .o_err(err1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Free count must track the number of zero busy bits.
   task automatic chk_pop(input string tag, input logic [7:0] busy, input logic [3:0] cnt);
      chk(tag, 32'(cnt), 32'(8 - $countones(busy)));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req0 = '0; ivld0 = '0; iidx0 = '0; flush0 = 1'b0;
      req1 = '0; ivld1 = '0; iidx1 = '0; flush1 = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // reset state
      chk("rst_cnt0", 32'(cnt0), 32'd8);
      chk("rst_empty0", 32'(empty0), 32'd1);
      chk("rst_full0", 32'(full0), 32'd0);
      chk("rst_selvld0", 32'(selvld0), 32'h3);
      chk("rst_sel0", 32'(sel0), 32'h08);
      chk("rst_alloc0", 32'(alloc0), 32'd1);
      chk("rst_busy0", 32'(busy0), 32'h00);
      chk("rst_err0", 32'(err0), 32'd0);
      chk("rst_sel1", 32'(sel1), 32'h08);
      chk("rst_cnt1", 32'(cnt1), 32'd8);

      // first grant of two
      req0 = 2'd2; #1;
      chk("req2_alloc0", 32'(alloc0), 32'd1);
      tick();
      req0 = 2'd0; #1;
      chk("a1_busy0", 32'(busy0), 32'h03);
      chk("a1_cnt0", 32'(cnt0), 32'd6);
      chk("a1_sel0", 32'(sel0), 32'h1A);
      chk_pop("a1_pop0", busy0, cnt0);

      // fill completely, then free entry 0
      req0 = 2'd2;
      tick(); tick(); tick();
      req0 = 2'd0;
      chk("fill_busy0", 32'(busy0), 32'hFF);
      ivld0 = 2'b01; iidx0 = 6'h00;
      tick();
      ivld0 = 2'b00; #1;
      chk("fe_busy0", 32'(busy0), 32'hFE);
      chk("fe_cnt0", 32'(cnt0), 32'd1);

      // one free entry: request 2 stalls, request 1 grants entry 0
      req0 = 2'd2; #1;
      chk("stall_alloc0", 32'(alloc0), 32'd0);
      chk("stall_selvld0", 32'(selvld0), 32'h1);
      chk("stall_sel0", 32'(sel0), 32'h00);
      tick();
      chk("stall_busy0", 32'(busy0), 32'hFE);
      req0 = 2'd1; #1;
      chk("one_alloc0", 32'(alloc0), 32'd1);
      tick();
      req0 = 2'd0; #1;
      chk("full_busy0", 32'(busy0), 32'hFF);
      chk("full_full0", 32'(full0), 32'd1);
      chk("full_cnt0", 32'(cnt0), 32'd0);
      chk("full_req0_alloc0", 32'(alloc0), 32'd1);
      chk("full_selvld0", 32'(selvld0), 32'h0);

      // free 3 and 5 while requesting 1 at full
      req0 = 2'd1; ivld0 = 2'b11; iidx0 = 6'h2B; #1;
      chk("fr35_alloc0", 32'(alloc0), 32'd0);
      tick();
      req0 = 2'd0; ivld0 = 2'b00; #1;
      chk("fr35_cnt0", 32'(cnt0), 32'd2);
      chk("fr35_sel0", 32'(sel0), 32'h2B);
      chk("fr35_busy0", 32'(busy0), 32'hD7);
      chk("fr35_selvld0", 32'(selvld0), 32'h3);
      chk_pop("fr35_pop0", busy0, cnt0);

      // flush with a request and an issue of busy entry 4 in the same cycle
      req0 = 2'd2; ivld0 = 2'b01; iidx0 = 6'h04; flush0 = 1'b1;
      tick();
      req0 = 2'd0; ivld0 = 2'b00; flush0 = 1'b0; #1;
      chk("fl_busy0", 32'(busy0), 32'h00);
      chk("fl_cnt0", 32'(cnt0), 32'd8);
      chk("fl_sel0", 32'(sel0), 32'h08);
      chk("fl_err0", 32'(err0), 32'd0);

      // errors: free a non-busy entry, then both ports on one index
      req0 = 2'd2;
      tick();
      req0 = 2'd0; ivld0 = 2'b01; iidx0 = 6'h06;
      tick();
      ivld0 = 2'b00; #1;
      chk("e1_err0", 32'(err0), 32'd1);
      chk("e1_busy0", 32'(busy0), 32'h03);
      chk("e1_cnt0", 32'(cnt0), 32'd6);
      ivld0 = 2'b11; iidx0 = 6'h09;
      tick();
      ivld0 = 2'b00; #1;
      chk("e2_err0", 32'(err0), 32'd1);
      chk("e2_busy0", 32'(busy0), 32'h01);
      chk("e2_cnt0", 32'(cnt0), 32'd7);
      chk_pop("e2_pop0", busy0, cnt0);
      tick(); tick();
      chk("e3_err0", 32'(err0), 32'd1);

      // rotating mode: allocate 0,1; free 0; next grant must be 2
      req1 = 2'd2;
      tick();
      req1 = 2'd0; #1;
      chk("r1_busy1", 32'(busy1), 32'h03);
      chk("r1_sel1", 32'(sel1), 32'h1A);
      ivld1 = 2'b01; iidx1 = 6'h00;
      tick();
      ivld1 = 2'b00; #1;
      chk("r2_busy1", 32'(busy1), 32'h02);
      chk("r2_sel1", 32'(sel1), 32'h1A);
      req1 = 2'd1;
      tick();
      req1 = 2'd0; #1;
      chk("r3_busy1", 32'(busy1), 32'h06);

      // drive ptr to 7 with busy 7E: grants wrap to {7,0}
      req1 = 2'd2;
      tick(); tick();
      req1 = 2'd0; #1;
      chk("wrap_busy1", 32'(busy1), 32'h7E);
      chk("wrap_sel1", 32'(sel1), 32'h07);
      chk("wrap_selvld1", 32'(selvld1), 32'h3);
      req1 = 2'd2;
      tick();
      req1 = 2'd0; #1;
      chk("wrap_busy1b", 32'(busy1), 32'hFF);
      chk("wrap_full1", 32'(full1), 32'd1);

      // ptr now 1: free 0 and 4, search order gives 4 before 0
      ivld1 = 2'b11; iidx1 = 6'h20;
      tick();
      ivld1 = 2'b00; #1;
      chk("rot_busy1", 32'(busy1), 32'hEE);
      chk("rot_sel1", 32'(sel1), 32'h04);
      chk_pop("rot_pop1", busy1, cnt1);

      // flush returns ptr to 0
      flush1 = 1'b1;
      tick();
      flush1 = 1'b0; #1;
      chk("fl_sel1", 32'(sel1), 32'h08);
      chk("fl_busy1", 32'(busy1), 32'h00);
      chk("fl_empty1", 32'(empty1), 32'd1);
      chk("fl_err1", 32'(err1), 32'd0);

      // reset clears the sticky error and all state
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      chk("rst2_err0", 32'(err0), 32'd0);
      chk("rst2_cnt0", 32'(cnt0), 32'd8);
      chk("rst2_busy0", 32'(busy0), 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
